// File: rtl/add_approx_pkg.sv
// Shared types and helpers for the lower-part-OR approximate adder.
// The golden model loa_sum works on up to MAX_W-bit operands so any W <= MAX_W can use it.
package add_approx_pkg;

  typedef enum logic {
    MODE_EXACT  = 1'b0,
    MODE_APPROX = 1'b1
  } mode_e;

  localparam int MAX_W = 32;

  // Width of the sum for a W-bit operand: the carry out lands in the extra top bit.
  function automatic int sum_w(input int w);
    return w + 1;
  endfunction

  // Reference lower-part-OR sum: OR in the low k bits, carry-in from the top approximate bit.
  function automatic logic [MAX_W:0] loa_sum(input logic [MAX_W-1:0] a,
                                             input logic [MAX_W-1:0] b,
                                             input int w,
                                             input int k);
    logic [MAX_W:0] lo;
    logic [MAX_W:0] hi;
    logic [MAX_W:0] res;
    logic           cin;
    lo  = '0;
    cin = 1'b0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < k)      lo[i] = a[i] | b[i];
      if (i == k - 1) cin   = a[i] & b[i];
    end
    hi  = (({1'b0, a} >> k) + ({1'b0, b} >> k) + (MAX_W+1)'(cin)) << k;
    res = hi | lo;
    for (int i = 0; i <= MAX_W; i++) begin
      if (i > w) res[i] = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/add_approx_err_mon.sv
// Error monitor: tracks |exact - out_sum| over approximate-mode results leaving the pipe.
// Only built when ADD_ERR_MON_EN is defined.
module add_approx_err_mon
  import add_approx_pkg::*;
#(
  parameter int W     = 8,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stat_clr,
  input  logic             ld_p2,
  input  logic [W-1:0]     a_p1,
  input  logic [W-1:0]     b_p1,
  input  logic             pop,
  input  mode_e            out_mode,
  input  logic [W:0]       out_sum,
  output logic [ACC_W-1:0] err_acc,
  output logic [ACC_W-1:0] err_cnt,
  output logic [W:0]       err_max
);

  logic [W:0]       exact_p2_d, exact_p2_q;
  logic [W:0]       err;
  logic [ACC_W-1:0] err_acc_d, err_acc_q;
  logic [ACC_W-1:0] err_cnt_d, err_cnt_q;
  logic [W:0]       err_max_d, err_max_q;

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] x,
                                               input logic [ACC_W-1:0] y);
    logic [ACC_W:0] s;
    s = {1'b0, x} + {1'b0, y};
    return s[ACC_W] ? '1 : s[ACC_W-1:0];
  endfunction

  function automatic logic [W:0] abs_diff(input logic [W:0] x, input logic [W:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

  // Exact sum follows the item entering S2 so it lines up with out_sum.
  always_comb begin
    exact_p2_d = exact_p2_q;
    if (ld_p2) exact_p2_d = {1'b0, a_p1} + {1'b0, b_p1};
  end

  // Counter update on output handshake; clear takes priority over a coincident sample.
  always_comb begin
    err       = abs_diff(exact_p2_q, out_sum);
    err_acc_d = err_acc_q;
    err_cnt_d = err_cnt_q;
    err_max_d = err_max_q;
    if (stat_clr) begin
      err_acc_d = '0;
      err_cnt_d = '0;
      err_max_d = '0;
    end else if (pop && out_mode == MODE_APPROX) begin
      err_acc_d = sat_add(err_acc_q, ACC_W'(err));
      err_cnt_d = sat_add(err_cnt_q, ACC_W'(err != '0));
      if (err > err_max_q) err_max_d = err;
    end
  end

  // Exact-sum register (data, no reset).
  always_ff @(posedge clk) begin
    exact_p2_q <= exact_p2_d;
  end

  // Monitor counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_acc_q <= '0;
      err_cnt_q <= '0;
      err_max_q <= '0;
    end else begin
      err_acc_q <= err_acc_d;
      err_cnt_q <= err_cnt_d;
      err_max_q <= err_max_d;
    end
  end

  assign err_acc = err_acc_q;
  assign err_cnt = err_cnt_q;
  assign err_max = err_max_q;

endmodule

// File: rtl/add_approx_pipe.sv
// Two-stage lower-part-OR approximate adder with valid/ready handshake.
// Define ADD_ERR_MON_EN to build the error monitor; otherwise its outputs read 0.
module add_approx_pipe
  import add_approx_pkg::*;
#(
  parameter int W     = 8,
  parameter int K     = 3,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W:0]       out_sum,
  output logic             out_mode,
  input  logic             stat_clr,
  output logic [ACC_W-1:0] err_acc,
  output logic [W:0]       err_max,
  output logic [ACC_W-1:0] err_cnt
);

  localparam int               SW      = sum_w(W);
  localparam logic [SW-1:0]    ONE_K   = SW'(1) << K;
  localparam logic [W-1:0]     LO_MASK = W'(ONE_K - SW'(1));
  localparam int               CI      = (K > 0) ? K - 1 : 0;

  logic          s1_ld, s2_ld;
  logic          vld_p1_d, vld_p1_q, vld_p2_d, vld_p2_q;
  logic [W-1:0]  lo_p1_d, lo_p1_q, hia_p1_d, hia_p1_q, hib_p1_d, hib_p1_q;
  logic          cin_p1_d, cin_p1_q;
  mode_e         mode_p1_d, mode_p1_q, mode_p2_d, mode_p2_q;
  logic [SW-1:0] sum_p2_d, sum_p2_q;

  // Handshake: a stage loads when empty or when its downstream stage is loading.
  always_comb begin
    s2_ld    = !vld_p2_q || out_ready;
    s1_ld    = !vld_p1_q || s2_ld;
    vld_p1_d = s1_ld ? in_valid : vld_p1_q;
    vld_p2_d = s2_ld ? vld_p1_q : vld_p2_q;
  end

  // S1: split operands; exact mode keeps full operands in the high path with no low part.
  always_comb begin
    lo_p1_d   = lo_p1_q;
    cin_p1_d  = cin_p1_q;
    hia_p1_d  = hia_p1_q;
    hib_p1_d  = hib_p1_q;
    mode_p1_d = mode_p1_q;
    if (s1_ld && in_valid) begin
      mode_p1_d = mode_e'(in_mode);
      if (mode_e'(in_mode) == MODE_APPROX) begin
        lo_p1_d  = (in_a | in_b) & LO_MASK;
        cin_p1_d = (K > 0) ? (in_a[CI] & in_b[CI]) : 1'b0;
        hia_p1_d = in_a & ~LO_MASK;
        hib_p1_d = in_b & ~LO_MASK;
      end else begin
        lo_p1_d  = '0;
        cin_p1_d = 1'b0;
        hia_p1_d = in_a;
        hib_p1_d = in_b;
      end
    end
  end

  // S2: high add with carry-in injected at bit K, low OR part merged in.
  always_comb begin
    sum_p2_d  = sum_p2_q;
    mode_p2_d = mode_p2_q;
    if (s2_ld && vld_p1_q) begin
      sum_p2_d  = ({1'b0, hia_p1_q} + {1'b0, hib_p1_q} + (cin_p1_q ? ONE_K : '0))
                  | {1'b0, lo_p1_q};
      mode_p2_d = mode_p1_q;
    end
  end

  // ---- stage boundary p1: operand split registers (data, no reset) ----
  always_ff @(posedge clk) begin
    lo_p1_q   <= lo_p1_d;
    cin_p1_q  <= cin_p1_d;
    hia_p1_q  <= hia_p1_d;
    hib_p1_q  <= hib_p1_d;
    mode_p1_q <= mode_p1_d;
  end

  // ---- stage boundary p2: valids and visible result, cleared by reset ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      sum_p2_q  <= '0;
      mode_p2_q <= MODE_EXACT;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      sum_p2_q  <= sum_p2_d;
      mode_p2_q <= mode_p2_d;
    end
  end

  assign in_ready  = s1_ld;
  assign out_valid = vld_p2_q;
  assign out_sum   = sum_p2_q;
  assign out_mode  = mode_p2_q;

`ifdef ADD_ERR_MON_EN
  logic [W-1:0] a_p1_d, a_p1_q, b_p1_d, b_p1_q;

  // Raw operands ride alongside S1 so the monitor can form the exact sum.
  always_comb begin
    a_p1_d = a_p1_q;
    b_p1_d = b_p1_q;
    if (s1_ld && in_valid) begin
      a_p1_d = in_a;
      b_p1_d = in_b;
    end
  end

  // Raw operand registers for the monitor.
  always_ff @(posedge clk) begin
    a_p1_q <= a_p1_d;
    b_p1_q <= b_p1_d;
  end

  add_approx_err_mon #(.W(W), .ACC_W(ACC_W)) u_err_mon (
    .clk      (clk),
    .rst      (rst),
    .stat_clr (stat_clr),
    .ld_p2    (s2_ld && vld_p1_q),
    .a_p1     (a_p1_q),
    .b_p1     (b_p1_q),
    .pop      (vld_p2_q && out_ready),
    .out_mode (mode_p2_q),
    .out_sum  (sum_p2_q),
    .err_acc  (err_acc),
    .err_cnt  (err_cnt),
    .err_max  (err_max)
  );
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign err_acc = '0;
  assign err_max = '0;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_add_approx_pipe.sv
// Directed bench for add_approx_pipe: K=3 main instance plus K=0 and K=W corner instances.
module tb_add_approx_pipe;
  localparam int W     = 8;
  localparam int ACC_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, in_valid, in_mode, out_ready, stat_clr;
  logic [W-1:0]     in_a, in_b;
  logic             in_ready, out_valid, out_mode;
  logic [W:0]       out_sum, err_max;
  logic [ACC_W-1:0] err_acc, err_cnt;
  logic             in_ready_k0, out_valid_k0, out_mode_k0;
  logic [W:0]       out_sum_k0, err_max_k0;
  logic [ACC_W-1:0] err_acc_k0, err_cnt_k0;
  logic             in_ready_kw, out_valid_kw, out_mode_kw;
  logic [W:0]       out_sum_kw, err_max_kw;
  logic [ACC_W-1:0] err_acc_kw, err_cnt_kw;

  int npass  = 0;
  int nfail  = 0;
  int ntotal = 0;

  logic [7:0] bp_a [6] = '{8'h10, 8'h07, 8'h04, 8'hFF, 8'h80, 8'h0B};
  logic [7:0] bp_b [6] = '{8'h20, 8'h01, 8'h04, 8'hFF, 8'h80, 8'h06};
  logic       bp_m [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [8:0] bp_e [6] = '{9'h030, 9'h007, 9'h00C, 9'h1FF, 9'h100, 9'h00F};

  add_approx_pipe #(.W(W), .K(3), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_mode(out_mode),
    .stat_clr(stat_clr), .err_acc(err_acc), .err_max(err_max), .err_cnt(err_cnt));

  add_approx_pipe #(.W(W), .K(0), .ACC_W(ACC_W)) dut_k0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_k0),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid_k0),
    .out_ready(out_ready), .out_sum(out_sum_k0), .out_mode(out_mode_k0),
    .stat_clr(stat_clr), .err_acc(err_acc_k0), .err_max(err_max_k0), .err_cnt(err_cnt_k0));

  add_approx_pipe #(.W(W), .K(W), .ACC_W(ACC_W)) dut_kw (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_kw),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid_kw),
    .out_ready(out_ready), .out_sum(out_sum_kw), .out_mode(out_mode_kw),
    .stat_clr(stat_clr), .err_acc(err_acc_kw), .err_max(err_max_kw), .err_cnt(err_cnt_kw));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) begin
      npass++;
    end else begin
      nfail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction through an idle pipe; results of all three instances checked.
  task automatic xfer(input logic [7:0] a, input logic [7:0] b, input logic m,
                      input logic [8:0] e3, input logic [8:0] e0, input logic [8:0] e8,
                      input string tag);
    out_ready = 1'b1;
    in_a      = a;
    in_b      = b;
    in_mode   = m;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    chk({tag, "_lat1_valid"}, 64'(out_valid), 64'd0);
    tick();
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_k3"}, 64'(out_sum), 64'(e3));
    chk({tag, "_mode"}, 64'(out_mode), 64'(m));
    chk({tag, "_k0"}, 64'(out_sum_k0), 64'(e0));
    chk({tag, "_kw"}, 64'(out_sum_kw), 64'(e8));
    tick();
  endtask

  initial begin
    int idx, npop;
    logic held;
    logic [8:0] hsum;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 1'b0;
    out_ready = 1'b1; stat_clr = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum",   64'(out_sum),   64'd0);
    chk("rst_out_mode",  64'(out_mode),  64'd0);
    chk("rst_err_acc",   64'(err_acc),   64'd0);
    chk("rst_err_max",   64'(err_max),   64'd0);
    chk("rst_err_cnt",   64'(err_cnt),   64'd0);
    rst = 1'b0;
    tick();

    // Directed vectors: exact, the approximate set, and the K=W pattern.
    xfer(8'hFF, 8'hFF, 1'b0, 9'h1FE, 9'h1FE, 9'h1FE, "exact_ff_ff");
    xfer(8'h07, 8'h01, 1'b1, 9'h007, 9'h008, 9'h007, "approx_07_01");
    xfer(8'h04, 8'h04, 1'b1, 9'h00C, 9'h008, 9'h004, "approx_04_04");
    xfer(8'hFF, 8'hFF, 1'b1, 9'h1FF, 9'h1FE, 9'h1FF, "approx_ff_ff");
    xfer(8'hAA, 8'h55, 1'b1, 9'h0FF, 9'h0FF, 9'h0FF, "approx_aa_55");

`ifdef ADD_ERR_MON_EN
    chk("mon_err_acc", 64'(err_acc), 64'd6);
    chk("mon_err_max", 64'(err_max), 64'd4);
    chk("mon_err_cnt", 64'(err_cnt), 64'd3);
    chk("mon_k0_acc",  64'(err_acc_k0), 64'd0);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("clr_err_acc", 64'(err_acc), 64'd0);
    chk("clr_err_max", 64'(err_max), 64'd0);
    chk("clr_err_cnt", 64'(err_cnt), 64'd0);
`else
    chk("nomon_err_acc", 64'(err_acc), 64'd0);
    chk("nomon_err_max", 64'(err_max), 64'd0);
    chk("nomon_err_cnt", 64'(err_cnt), 64'd0);
`endif

    // Backpressure: six transactions, consumer stalled for the first five cycles.
    idx = 0; npop = 0; held = 1'b0; hsum = '0;
    for (int cyc = 0; cyc < 40 && npop < 6; cyc++) begin
      in_valid = (idx < 6);
      if (idx < 6) begin
        in_a    = bp_a[idx];
        in_b    = bp_b[idx];
        in_mode = bp_m[idx];
      end
      out_ready = (cyc >= 5);
      #1;
      if (cyc == 2) begin
        chk("bp_in_ready_drop", 64'(in_ready), 64'd0);
        chk("bp_accepted_two",  64'(idx),      64'd2);
      end
      if (held) begin
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
        chk("bp_hold_sum",   64'(out_sum),   64'(hsum));
      end
      held = out_valid && !out_ready;
      hsum = out_sum;
      if (out_valid && out_ready) begin
        if (npop < 6) chk($sformatf("bp_order_%0d", npop), 64'(out_sum), 64'(bp_e[npop]));
        npop++;
      end
      if (in_valid && in_ready) idx++;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_all_out", 64'(npop), 64'd6);
    tick();

    // Reset with both stages full: nothing in flight may appear afterwards.
    out_ready = 1'b0;
    in_mode   = 1'b0;
    in_a      = 8'h01;
    in_b      = 8'h02;
    in_valid  = 1'b1;
    tick();
    in_a = 8'h03;
    tick();
    in_valid = 1'b0;
    chk("rst_pre_valid", 64'(out_valid), 64'd1);
    chk("rst_pre_full",  64'(in_ready),  64'd0);
    chk("rst_pre_sum",   64'(out_sum),   64'h003);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_flush_valid", 64'(out_valid), 64'd0);
    chk("rst_flush_sum",   64'(out_sum),   64'd0);
    out_ready = 1'b1;
    repeat (4) begin
      tick();
      chk("rst_no_stale", 64'(out_valid), 64'd0);
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
